// File: rtl/v_cu_pkg.sv
// Shared vector CU definitions: geometry helpers and the address generator enums.
package v_cu_pkg;

  // Number of base pointers carried per operand (one per register of an LMUL=8 group).
  localparam int unsigned NumPtrs = 8;

  // Row address width within one lane's VRF slice.
  function automatic int unsigned aw_of(int unsigned vlen, int unsigned lanes);
    return $clog2(vlen / lanes);
  endfunction

  // 32-bit rows each register occupies in one lane.
  function automatic int unsigned reg_rows_of(int unsigned vlen, int unsigned lanes);
    return vlen / 32 / lanes;
  endfunction

  // Rows touched by a full LMUL=8 group.
  function automatic int unsigned max_rows_of(int unsigned vlen, int unsigned lanes);
    return NumPtrs * reg_rows_of(vlen, lanes);
  endfunction

  typedef enum logic [1:0] {
    Sew8    = 2'b00,
    Sew16   = 2'b01,
    Sew32   = 2'b10,
    Sew32Rs = 2'b11
  } sew_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFin
  } addr_gen_state_t;

endpackage

// File: rtl/vrf_row_addr.sv
// Maps a row index of a register group onto a VRF row address.
module vrf_row_addr import v_cu_pkg::*; #(
  parameter int unsigned VLEN      = 4096,
  parameter int unsigned VLANE_NUM = 8,
  localparam int unsigned AW       = aw_of(VLEN, VLANE_NUM),
  localparam int unsigned RIW      = $clog2(max_rows_of(VLEN, VLANE_NUM))
) (
  input  logic [RIW-1:0]        row,
  input  logic [NumPtrs*AW-1:0] bases,
  output logic [AW-1:0]         addr
);

  localparam int unsigned OW = $clog2(reg_rows_of(VLEN, VLANE_NUM));

  logic [RIW-OW-1:0] ptr_idx;
  logic [OW-1:0]     offset;
  logic [AW-1:0]     ptr [NumPtrs];

  assign ptr_idx = row[RIW-1:OW];
  assign offset  = row[OW-1:0];

  // Unpack the concatenated base pointer bus.
  always_comb begin
    for (int k = 0; k < NumPtrs; k++) begin
      ptr[k] = bases[k*AW +: AW];
    end
  end

  // Register base plus in-register offset; wraps modulo 2^AW.
  always_comb begin
    addr = ptr[ptr_idx] + AW'(offset);
  end

endmodule

// File: rtl/vrf_addr_gen.sv
// Per-instruction VRF row address sequencer for vs1/vs2 reads and vd writes.
module vrf_addr_gen import v_cu_pkg::*; #(
  parameter int unsigned VLEN      = 4096,
  parameter int unsigned VLANE_NUM = 8,
  localparam int unsigned AW       = aw_of(VLEN, VLANE_NUM),
  localparam int unsigned VW       = $clog2(VLEN) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_vld_i,
  output logic                  start_rdy_o,
  input  logic [NumPtrs*AW-1:0] vrf_starting_raddr0_i,
  input  logic [NumPtrs*AW-1:0] vrf_starting_raddr1_i,
  input  logic [NumPtrs*AW-1:0] vrf_starting_waddr_i,
  input  logic [VW-1:0]         vl_i,
  input  logic [1:0]            sew_i,
  output logic [AW-1:0]         vrf_raddr0_o,
  output logic [AW-1:0]         vrf_raddr1_o,
  output logic                  vrf_rd_vld_o,
  input  logic                  vrf_rd_rdy_i,
  output logic [AW-1:0]         vrf_waddr_o,
  input  logic                  wr_result_vld_i,
  output logic                  vrf_wen_o,
  output logic                  done_o
);

  localparam int unsigned MaxRows = max_rows_of(VLEN, VLANE_NUM);
  localparam int unsigned RIW     = $clog2(MaxRows);
  localparam int unsigned RW      = RIW + 1;
  localparam int unsigned VlW     = VW + 1;
  localparam int unsigned LgLanes = $clog2(VLANE_NUM);
  localparam int unsigned BW      = NumPtrs * AW;

  addr_gen_state_t state_q, state_d;
  logic [RW-1:0]   rows_q, rows_d, rows_calc;
  logic [RW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [RW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [BW-1:0]   base0_q, base0_d, base1_q, base1_d, basew_q, basew_d;
  logic [AW-1:0]   raddr0_q, raddr1_q, waddr_q;
  logic [AW-1:0]   raddr0_nxt, raddr1_nxt, waddr_nxt;
  logic [VlW-1:0]  vl_round, rows_raw;
  int unsigned     row_sh;
  logic            accept, rd_fire, wen, addr_upd;

  // Row count: ceil(vl / elements-per-row), elements-per-row is a power of two.
  always_comb begin
    case (sew_t'(sew_i))
      Sew8:    row_sh = LgLanes + 2;
      Sew16:   row_sh = LgLanes + 1;
      default: row_sh = LgLanes;
    endcase
    vl_round  = {1'b0, vl_i} + (VlW'(1) << row_sh) - VlW'(1);
    rows_raw  = vl_round >> row_sh;
    rows_calc = (rows_raw > VlW'(MaxRows)) ? RW'(MaxRows) : rows_raw[RW-1:0];
  end

  // Next-state, counter and handshake logic.
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    base0_d  = base0_q;
    base1_d  = base1_q;
    basew_d  = basew_q;
    accept   = 1'b0;
    rd_fire  = 1'b0;
    wen      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_vld_i) begin
          accept   = 1'b1;
          rows_d   = rows_calc;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          base0_d  = vrf_starting_raddr0_i;
          base1_d  = vrf_starting_raddr1_i;
          basew_d  = vrf_starting_waddr_i;
          state_d  = (rows_calc == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        rd_fire  = vrf_rd_rdy_i;
        // Write window compares against the pre-increment read count.
        wen      = wr_result_vld_i && (wr_cnt_q < rd_cnt_q);
        rd_cnt_d = rd_cnt_q + RW'(rd_fire);
        wr_cnt_d = wr_cnt_q + RW'(wen);
        if (wr_cnt_d == rows_q) begin
          state_d = StFin;
        end else if (rd_cnt_d == rows_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        wen      = wr_result_vld_i && (wr_cnt_q < rd_cnt_q);
        wr_cnt_d = wr_cnt_q + RW'(wen);
        if (wr_cnt_d == rows_q) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign addr_upd = accept || (state_q == StRun) || (state_q == StDrain);

  // Address of the row each counter will point at next cycle, so outputs can be registered.
  vrf_row_addr #(
    .VLEN      (VLEN),
    .VLANE_NUM (VLANE_NUM)
  ) u_row_vs1 (
    .row   (rd_cnt_d[RIW-1:0]),
    .bases (base0_d),
    .addr  (raddr0_nxt)
  );

  vrf_row_addr #(
    .VLEN      (VLEN),
    .VLANE_NUM (VLANE_NUM)
  ) u_row_vs2 (
    .row   (rd_cnt_d[RIW-1:0]),
    .bases (base1_d),
    .addr  (raddr1_nxt)
  );

  vrf_row_addr #(
    .VLEN      (VLEN),
    .VLANE_NUM (VLANE_NUM)
  ) u_row_vd (
    .row   (wr_cnt_d[RIW-1:0]),
    .bases (basew_d),
    .addr  (waddr_nxt)
  );

  // FSM state and row counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      rows_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Base pointers latched at start; the renaming stage may move on afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base0_q <= '0;
      base1_q <= '0;
      basew_q <= '0;
    end else begin
      base0_q <= base0_d;
      base1_q <= base1_d;
      basew_q <= basew_d;
    end
  end

  // Registered row addresses; held while idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raddr0_q <= '0;
      raddr1_q <= '0;
      waddr_q  <= '0;
    end else if (addr_upd) begin
      raddr0_q <= raddr0_nxt;
      raddr1_q <= raddr1_nxt;
      waddr_q  <= waddr_nxt;
    end
  end

  assign start_rdy_o  = (state_q == StIdle);
  assign vrf_rd_vld_o = (state_q == StRun);
  assign done_o       = (state_q == StFin);
  assign vrf_wen_o    = wen;
  assign vrf_raddr0_o = raddr0_q;
  assign vrf_raddr1_o = raddr1_q;
  assign vrf_waddr_o  = waddr_q;

endmodule

// File: tb/tb_vrf_addr_gen.sv
// Directed bench for vrf_addr_gen with hand-computed row address sequences.
module tb_vrf_addr_gen;

  localparam int unsigned AW = 9;
  localparam int unsigned BW = 8 * AW;
  localparam int unsigned VW = 13;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_vld = 1'b0;
  logic          start_rdy;
  logic [BW-1:0] rbus0 = '0;
  logic [BW-1:0] rbus1 = '0;
  logic [BW-1:0] wbus = '0;
  logic [VW-1:0] vl = '0;
  logic [1:0]    sew = '0;
  logic [AW-1:0] raddr0, raddr1, waddr;
  logic          rd_vld;
  logic          rd_rdy = 1'b0;
  logic          wr_vld = 1'b0;
  logic          wen;
  logic          done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vrf_addr_gen #(
    .VLEN      (4096),
    .VLANE_NUM (8)
  ) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .start_vld_i           (start_vld),
    .start_rdy_o           (start_rdy),
    .vrf_starting_raddr0_i (rbus0),
    .vrf_starting_raddr1_i (rbus1),
    .vrf_starting_waddr_i  (wbus),
    .vl_i                  (vl),
    .sew_i                 (sew),
    .vrf_raddr0_o          (raddr0),
    .vrf_raddr1_o          (raddr1),
    .vrf_rd_vld_o          (rd_vld),
    .vrf_rd_rdy_i          (rd_rdy),
    .vrf_waddr_o           (waddr),
    .wr_result_vld_i       (wr_vld),
    .vrf_wen_o             (wen),
    .done_o                (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pointers for register group starting at vN: (N+k)*16.
  function automatic logic [BW-1:0] contig(input int unsigned rg);
    logic [BW-1:0] b;
    for (int k = 0; k < 8; k++) begin
      b[k*AW +: AW] = AW'((rg + k) * 16);
    end
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic start_instr(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                             input logic [BW-1:0] bw, input int unsigned vlen,
                             input logic [1:0] s);
    int unsigned waited = 0;
    while (!start_rdy && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    rbus0     = b0;
    rbus1     = b1;
    wbus      = bw;
    vl        = VW'(vlen);
    sew       = s;
    start_vld = 1'b1;
    @(negedge clk);
    check("start_rdy", 32'(start_rdy), 1);
    @(posedge clk); #1;
    start_vld = 1'b0;
  endtask

  // Walk all read rows of a contiguous vs1 group, optionally with random stalls.
  task automatic read_all(input int unsigned n, input int unsigned rg, input bit rnd,
                          input string tag);
    int unsigned row = 0;
    bit rdy;
    for (int c = 0; c < int'(n) + 200; c++) begin
      rdy    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_rdy = rdy;
      @(negedge clk);
      if (!rd_vld) break;
      check({tag, "_raddr0"}, 32'(raddr0), (rg * 16 + row) % 512);
      if (rdy) row++;
      @(posedge clk); #1;
    end
    rd_rdy = 1'b0;
    check({tag, "_rows"}, row, n);
    @(posedge clk); #1;
  endtask

  // Return results every cycle until done; vd group is contiguous from vN.
  task automatic drain(input int unsigned n, input int unsigned rg, input string tag);
    int unsigned cnt = 0;
    int last_w = -1;
    int done_at = -1;
    wr_vld = 1'b1;
    for (int c = 0; c < int'(n) + 20 && done_at < 0; c++) begin
      @(negedge clk);
      if (wen) begin
        check({tag, "_waddr"}, 32'(waddr), rg * 16 + cnt);
        cnt++;
        last_w = c;
      end
      if (done) done_at = c;
      @(posedge clk); #1;
    end
    wr_vld = 1'b0;
    check({tag, "_writes"}, cnt, n);
    check({tag, "_done_gap"}, 32'(done_at - last_w), 1);
    @(negedge clk);
    check({tag, "_idle"}, 32'(start_rdy), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] b;
    logic [7:0] exp_rd, exp_wen, exp_done;
    int unsigned wr_seen;

    // Reset state, with a result presented to confirm it is ignored.
    wr_vld = 1'b1;
    #12;
    check("rst_start_rdy", 32'(start_rdy), 1);
    check("rst_rd_vld", 32'(rd_vld), 0);
    check("rst_wen", 32'(wen), 0);
    check("rst_done", 32'(done), 0);
    check("rst_raddr0", 32'(raddr0), 0);
    check("rst_waddr", 32'(waddr), 0);
    wr_vld = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // T1: vs1=v2, vs2=v6, vd=v4, vl=32, sew=32 -> 4 rows.
    start_instr(contig(2), contig(6), contig(4), 32, 2'b10);
    for (int i = 0; i < 4; i++) begin
      rd_rdy = 1'b1;
      @(negedge clk);
      check("t1_rd_vld", 32'(rd_vld), 1);
      check("t1_raddr0", 32'(raddr0), 32 + i);
      check("t1_raddr1", 32'(raddr1), 96 + i);
      check("t1_waddr_hold", 32'(waddr), 64);
      @(posedge clk); #1;
    end
    rd_rdy = 1'b0;
    @(negedge clk);
    check("t1_drain_no_rd", 32'(rd_vld), 0);
    check("t1_drain_no_done", 32'(done), 0);
    @(posedge clk); #1;
    drain(4, 4, "t1");

    // T2: vl=200, sew=32 -> 25 rows spanning two registers; vs2 pointer 0 wraps.
    b = '0;
    b[0*AW +: AW] = AW'(505);
    b[1*AW +: AW] = AW'(300);
    start_instr(contig(8), b, contig(16), 200, 2'b10);
    for (int i = 0; i < 25; i++) begin
      rd_rdy = 1'b1;
      @(negedge clk);
      check("t2_rd_vld", 32'(rd_vld), 1);
      check("t2_raddr0", 32'(raddr0), 128 + i);
      check("t2_raddr1", 32'(raddr1), (i < 16) ? (505 + i) % 512 : 300 + i - 16);
      @(posedge clk); #1;
    end
    rd_rdy = 1'b0;
    @(negedge clk);
    check("t2_rd_vld_drop", 32'(rd_vld), 0);
    @(posedge clk); #1;
    drain(25, 16, "t2");

    // T3: random backpressure, vl=128 sew=16 -> 8 rows.
    start_instr(contig(3), contig(0), contig(7), 128, 2'b01);
    read_all(8, 3, 1'b1, "t3");
    drain(8, 7, "t3");

    // T4: results offered every cycle from acceptance; vl=40 sew=32 -> 5 rows.
    exp_rd   = 8'b0001_1111;
    exp_wen  = 8'b0011_1110;
    exp_done = 8'b0100_0000;
    wr_seen  = 0;
    rd_rdy   = 1'b1;
    wr_vld   = 1'b1;
    start_instr(contig(1), contig(0), contig(10), 40, 2'b10);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t4_rd_vld", 32'(rd_vld), 32'(exp_rd[c]));
      check("t4_wen", 32'(wen), 32'(exp_wen[c]));
      check("t4_done", 32'(done), 32'(exp_done[c]));
      if (wen) begin
        check("t4_waddr", 32'(waddr), 160 + wr_seen);
        wr_seen++;
      end
      @(posedge clk); #1;
    end
    check("t4_writes", wr_seen, 5);
    rd_rdy = 1'b0;
    wr_vld = 1'b0;

    // T5a: vl=0 -> done next cycle, nothing else.
    wr_vld = 1'b1;
    start_instr(contig(0), contig(0), contig(0), 0, 2'b10);
    @(negedge clk);
    check("t5a_done", 32'(done), 1);
    check("t5a_rd_vld", 32'(rd_vld), 0);
    check("t5a_wen", 32'(wen), 0);
    @(posedge clk); #1;
    wr_vld = 1'b0;
    @(negedge clk);
    check("t5a_idle", 32'(start_rdy), 1);
    check("t5a_done_clr", 32'(done), 0);
    @(posedge clk); #1;

    // T5b: sew=8, vl=33 -> 2 rows.
    start_instr(contig(5), contig(0), contig(12), 33, 2'b00);
    read_all(2, 5, 1'b0, "t5b");
    drain(2, 12, "t5b");

    // T5c: sew=11 behaves as 32-bit, vl=9 -> 2 rows.
    start_instr(contig(9), contig(0), contig(13), 9, 2'b11);
    read_all(2, 9, 1'b0, "t5c");
    drain(2, 13, "t5c");

    // T5d: vl=4096 sew=32 would be 512 rows, clamped to 128.
    start_instr(contig(20), contig(0), contig(0), 4096, 2'b10);
    read_all(128, 20, 1'b0, "t5d");
    drain(128, 0, "t5d");

    // T6: reset mid-run at row 5, then a fresh instruction starts from row 0.
    start_instr(contig(8), contig(0), contig(4), 256, 2'b10);
    rd_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t6_row5", 32'(raddr0), 133);
    #1;
    rstn = 1'b0;
    #1;
    check("t6_rst_rd_vld", 32'(rd_vld), 0);
    check("t6_rst_raddr0", 32'(raddr0), 0);
    check("t6_rst_start_rdy", 32'(start_rdy), 1);
    check("t6_rst_done", 32'(done), 0);
    rd_rdy = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    start_instr(contig(2), contig(0), contig(4), 32, 2'b10);
    read_all(4, 2, 1'b0, "t6");
    drain(4, 4, "t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vrf_addr_gen.md
# vrf_addr_gen

Per-instruction VRF address sequencer sitting directly downstream of the vector CU's register renaming stage. Accepts the eight concatenated per-register base pointers for vs1, vs2 and vd, plus vl and SEW. Walks the row addresses an instruction touches across up to LMUL=8 consecutive registers: read rows to the VRF read ports under valid/ready, write rows as lane results return. Signals completion with a one-cycle done pulse.

## Interface
Parameters:
- VLEN, 4096, vector register length in bits
- VLANE_NUM, 8, number of vector lanes
- Derived: AW = $clog2(VLEN/VLANE_NUM) = 9; REG_ROWS = VLEN/32/VLANE_NUM = 16 rows per register per lane; MAX_ROWS = 8*REG_ROWS = 128

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_vld_i  in  1  new instruction addresses/vl valid
- start_rdy_o  out  1  block idle, start accepted when start_vld_i & start_rdy_o
- vrf_starting_raddr0_i  in  8*AW  vs1 base pointers, pointer k in bits [k*AW +: AW]
- vrf_starting_raddr1_i  in  8*AW  vs2 base pointers
- vrf_starting_waddr_i  in  8*AW  vd base pointers
- vl_i  in  $clog2(VLEN)+1  element count
- sew_i  in  2  00=8b, 01=16b, 10=32b, 11 treated as 32b
- vrf_raddr0_o, vrf_raddr1_o  out  AW  current read row addresses
- vrf_rd_vld_o  out  1  read addresses valid
- vrf_rd_rdy_i  in  1  VRF accepts read addresses
- vrf_waddr_o  out  AW  current write row address
- wr_result_vld_i  in  1  lanes present a result row this cycle
- vrf_wen_o  out  1  write enable for vrf_waddr_o
- done_o  out  1  one-cycle pulse, instruction complete

## Operation
- Rows: epr = VLANE_NUM*(4>>sew), rows = ceil(vl_i/epr), clamped to MAX_ROWS; latched at start.
- Row r maps to address base[r / REG_ROWS] + (r % REG_ROWS); pointer index is r[6:4], offset is r[3:0]. Addition is AW bits, wraps modulo 2^AW.
- Two counters: rd_cnt (advances on vrf_rd_vld_o & vrf_rd_rdy_i), wr_cnt (advances on vrf_wen_o).
- vrf_wen_o = wr_result_vld_i & (state in RUN/DRAIN) & (wr_cnt < rd_cnt). Results outside this window are dropped.
- FSM states:
  - IDLE: start_rdy_o=1. On start go to RUN, or to FIN if rows=0.
  - RUN: vrf_rd_vld_o=1. After the last read handshake (rd_cnt reaches rows), go to DRAIN.
  - DRAIN: no reads; wait for writes.
  - FIN: done_o=1 for one cycle, then IDLE.
- From RUN or DRAIN, go to FIN on the cycle after the last write handshake.
- Reads and writes in the same cycle are both honoured.
- A write on the final read cycle counts toward wr_cnt (wr_cnt < rd_cnt is evaluated pre-increment).

## Timing
- Reset (async, any state): state=IDLE, counters=0, all outputs 0 except start_rdy_o=1. An in-flight instruction is discarded.
- Start accepted at cycle T: vrf_rd_vld_o=1 with row-0 addresses at T+1. All address outputs are registered.
- vrf_rd_vld_o holds and addresses are stable while vrf_rd_rdy_i=0. Each handshake advances to the next row the next cycle. Throughput is 1 row/cycle.
- vrf_waddr_o is registered and shows row wr_cnt; vrf_wen_o is combinational from wr_result_vld_i.
- done_o is asserted one cycle after the final write handshake. start_rdy_o rises the cycle after done_o.
- vl_i=0: start at T, done_o at T+1, no reads or writes.

## Structure
- Shared package v_cu_pkg: AW/REG_ROWS/MAX_ROWS localparam functions of VLEN/VLANE_NUM, sew_t enum, addr_gen_state_t enum.
- Sub-module vrf_row_addr: combinational pointer select plus offset add, row index and 8*AW bus in, AW address out.
  - Instantiated three times: vs1, vs2, vd.

## Test plan
- vs1 base=v2 (pointers 32,48,…), vl=32, sew=32, rdy=1: raddr0 = 32,33,34,35 at T+1..T+4; four results give waddr (vd=v4) 64..67; done_o one cycle after the fourth write.
- vl=200, sew=32 (25 rows), vs1 base=v8: raddr0 = 128..143 then 144..152; vrf_rd_vld_o drops after row 24.
- Random vrf_rd_rdy_i backpressure: addresses held while stalled, no row skipped or repeated.
- wr_result_vld_i asserted every cycle from T: vrf_wen_o only while wr_cnt<rd_cnt, and exactly `rows` writes.
- vl=0: done_o at T+1, no rd_vld or wen. sew=8, vl=33: exactly 2 rows.
- rstn low mid-RUN at row 5: outputs clear immediately; a new start after reset begins at row 0.
